memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-port arbiter and sequencer for the shared 256x8 `memory` block. It accepts independent read/write requests from two masters, normally the CPU control unit (port 0) and the program loader/debug port (port 1). It serialises them onto the memory's single `get`/`set` interface and returns read data with a one-cycle valid pulse. It sits directly between the masters and `memory`, and is the only driver of the memory's `addr`, `val`, `get` and `set` inputs.

## Interface
- `FAIR`, default 1: 1 = round-robin between ports; 0 = fixed priority, port 0 always wins.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` input 1: request pending; held until the matching `ready` pulse.
- `req0_write` / `req1_write` input 1: 1 = write, 0 = read.
- `req0_addr` / `req1_addr` input 8: memory address.
- `req0_wdata` / `req1_wdata` input 8: write data; ignored for reads.
- `req0_ready` / `req1_ready` output 1: one-cycle pulse, request accepted.
- `req0_rvalid` / `req1_rvalid` output 1: one-cycle pulse, `reqN_rdata` holds read data.
- `req0_rdata` / `req1_rdata` output 8: read data; holds its value until the next read on that port.
- `mem_addr` output 8: to `memory.addr`.
- `mem_val` output 8: to `memory.val`.
- `mem_get` output 1: to `memory.get`.
- `mem_set` output 1: to `memory.set`.
- `mem_out` input 8: from `memory.out`.
- `grant_id` output 1: port currently owning the memory; debug only.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- **IDLE**
  - No valid request: stay in IDLE.
  - One or more valid: pick a winner and latch its write/addr/wdata into `mem_*` registers. Set `mem_set` = write and `mem_get` = !write. Assert the winner's `ready`, set `grant_id`, and go to ISSUE.
- **ISSUE**
  - `mem_get`/`mem_set` are high for exactly this cycle; the memory acts on the closing edge.
  - Write: go to IDLE, clearing `mem_set`.
  - Read: go to RESP, clearing `mem_get`.
- **RESP**
  - `mem_out` is valid in this cycle.
  - On the closing edge, capture it into the granted port's `rdata`, pulse that port's `rvalid` for one cycle, and go to IDLE.
- **Arbitration**
  - `last_grant` register.
  - FAIR=1 with both ports valid: grant `!last_grant`.
  - Single valid port: grant that port.
  - `last_grant` updates on every grant.
  - FAIR=0: port 0 always wins.
- `mem_set` and `mem_get` are never high in the same cycle.
- The arbiter samples `req*_valid` only in IDLE. A request dropped before `ready` is ignored with no side effects.
- The arbiter does not forward between ports. Ordering is strictly grant order, so a read granted after a write to the same address returns the new data.

## Timing
- Reset value of every output: 0, including `rdata`.
- Reset values of internal state:
  - state = IDLE.
  - `last_grant` = 1, so port 0 wins the first contended grant.
- Cycle numbering: E0 is the edge at which IDLE samples valid.
- `ready` is high in the cycle after E0.
- A write is committed at E1.
- Read: `rvalid` and `rdata` are visible after E2.
  - Read latency is 3 cycles from sample to `rvalid`.
  - Write occupancy is 2 cycles.
- `rvalid` coincides with IDLE, so a new request is sampled in the same cycle.
  - Sustained throughput is one read per 3 cycles or one write per 2 cycles.
- A master may deassert `valid` or change its fields in the cycle `ready` is high; the arbiter has already latched them.
- Reset asserted mid-operation:
  - All outputs clear immediately; `mem_set`/`mem_get` drop asynchronously.
  - An in-flight write whose ISSUE edge has not yet occurred is not performed.
  - A pending read gets no `rvalid`.

## Structure
- Package `memory_arbiter_pkg` holds:
  - the state enum (IDLE/ISSUE/RESP);
  - port ID constants `PORT_CPU` = 0 and `PORT_LOADER` = 1;
  - `ADDR_W` = 8 and `DATA_W` = 8.
- Sub-module `rr_pick2`: combinational 2-way round-robin/priority picker.
  - Inputs: two valids, `last_grant`, FAIR.
  - Outputs: grant index and any-valid.
- The top level holds the FSM, latch registers and response steering.

## Test plan
- **Single write then read:** port 0 writes 0x5A to 0x10, then reads 0x10.
  - Required: `req0_ready` one cycle after each sample.
  - Required: `req0_rvalid` 3 cycles after the read sample, with `req0_rdata` = 0x5A.
  - Required: port 1 outputs stay 0.
- **Contention, FAIR=1:** both ports hold valid reads continuously, to 0x01 and 0x02.
  - Required: grants alternate 0,1,0,1, with port 0 first after reset.
  - Required: `rdata` = the memory contents at 0x01 and 0x02 respectively.
  - Required: `mem_get` is never high two consecutive cycles.
- **Contention, FAIR=0:** both ports hold valid continuously.
  - Required: port 0 is granted every time and port 1 is starved.
  - Port 1 then drops valid, leaving port 0 as the only valid port. Required: port 0 continues to be granted and `mem_set`/`mem_get` are never high together.
- **Cross-port coherence:** port 1 writes 0xC3 to 0xFF, and port 0 reads 0xFF one cycle later.
  - Required: port 0 is granted after the write's ISSUE cycle and returns 0xC3.
- **Reset mid-write:** drop `rst_n` during ISSUE of a write of 0x77 to 0x20.
  - Required: all outputs are 0 within the same cycle.
  - Required: a later read of 0x20 returns the old value.
- **Abandoned request:** raise then drop `req1_valid` while port 0's read is in RESP.
  - Required: no `req1_ready` and no memory access for port 1.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package memory_arbiter_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker: round-robin when FAIR, else port 0 priority.
module rr_pick2
    import memory_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic any_valid
);

    always_comb begin
        grant     = PORT_CPU;
        any_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            grant = FAIR ? ~last_grant : PORT_CPU;
        end else if (valid1) begin
            grant = PORT_LOADER;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises two masters onto the single get/set port of the shared 256x8 memory
// and steers read data back to the granted port with a one-cycle rvalid pulse.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_val,
    output logic              mem_get,
    output logic              mem_set,
    input  logic [DATA_W-1:0] mem_out,
    output logic              grant_id
);

    state_e              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_val_q, mem_val_d;
    logic                mem_get_q, mem_get_d;
    logic                mem_set_q, mem_set_d;
    logic                ready0_q, ready0_d, ready1_q, ready1_d;
    logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                pick_grant, pick_any;

    rr_pick2 #(.FAIR(FAIR)) u_pick (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .any_valid  (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        mem_addr_d   = mem_addr_q;
        mem_val_d    = mem_val_q;
        mem_get_d    = 1'b0;
        mem_set_d    = 1'b0;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d      = ISSUE;
                    grant_d      = pick_grant;
                    last_grant_d = pick_grant;
                    if (pick_grant == PORT_LOADER) begin
                        mem_addr_d = req1_addr;
                        mem_val_d  = req1_wdata;
                        mem_set_d  = req1_write;
                        mem_get_d  = ~req1_write;
                        ready1_d   = 1'b1;
                    end else begin
                        mem_addr_d = req0_addr;
                        mem_val_d  = req0_wdata;
                        mem_set_d  = req0_write;
                        mem_get_d  = ~req0_write;
                        ready0_d   = 1'b1;
                    end
                end
            end
            // mem_set_q still records whether the issued op was a write.
            ISSUE: state_d = mem_set_q ? IDLE : RESP;
            RESP: begin
                state_d = IDLE;
                if (grant_q == PORT_LOADER) begin
                    rdata1_d  = mem_out;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = mem_out;
                    rvalid0_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_LOADER;
            grant_q      <= PORT_CPU;
            mem_addr_q   <= '0;
            mem_val_q    <= '0;
            mem_get_q    <= 1'b0;
            mem_set_q    <= 1'b0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_val_q    <= mem_val_d;
            mem_get_q    <= mem_get_d;
            mem_set_q    <= mem_set_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign req0_ready  = ready0_q;
    assign req1_ready  = ready1_q;
    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;
    assign mem_addr    = mem_addr_q;
    assign mem_val     = mem_val_q;
    assign mem_get     = mem_get_q;
    assign mem_set     = mem_set_q;
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench: a FAIR=1 arbiter (a_*) and a FAIR=0 arbiter (b_*), each with its own memory model.
module tb_memory_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int failed   = 0;

    logic       a_req0_valid = 0, a_req0_write = 0, a_req1_valid = 0, a_req1_write = 0;
    logic [7:0] a_req0_addr = 0, a_req0_wdata = 0, a_req1_addr = 0, a_req1_wdata = 0;
    logic       a_req0_ready, a_req0_rvalid, a_req1_ready, a_req1_rvalid;
    logic [7:0] a_req0_rdata, a_req1_rdata, a_mem_addr, a_mem_val;
    logic [7:0] a_mem_out = 0;
    logic       a_mem_get, a_mem_set, a_grant_id;

    logic       b_req0_valid = 0, b_req1_valid = 0;
    logic [7:0] b_req0_addr = 0, b_req1_addr = 0;
    logic       b_req0_ready, b_req0_rvalid, b_req1_ready, b_req1_rvalid;
    logic [7:0] b_req0_rdata, b_req1_rdata, b_mem_addr, b_mem_val;
    logic [7:0] b_mem_out = 0;
    logic       b_mem_get, b_mem_set, b_grant_id;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    logic [38:0] a_outs, b_outs;
    assign a_outs = {a_req0_ready, a_req1_ready, a_req0_rvalid, a_req1_rvalid, a_req0_rdata,
                     a_req1_rdata, a_mem_addr, a_mem_val, a_mem_get, a_mem_set, a_grant_id};
    assign b_outs = {b_req0_ready, b_req1_ready, b_req0_rvalid, b_req1_rvalid, b_req0_rdata,
                     b_req1_rdata, b_mem_addr, b_mem_val, b_mem_get, b_mem_set, b_grant_id};

    memory_arbiter #(.FAIR(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(a_req0_valid), .req0_write(a_req0_write), .req0_addr(a_req0_addr),
        .req0_wdata(a_req0_wdata), .req0_ready(a_req0_ready), .req0_rvalid(a_req0_rvalid),
        .req0_rdata(a_req0_rdata),
        .req1_valid(a_req1_valid), .req1_write(a_req1_write), .req1_addr(a_req1_addr),
        .req1_wdata(a_req1_wdata), .req1_ready(a_req1_ready), .req1_rvalid(a_req1_rvalid),
        .req1_rdata(a_req1_rdata),
        .mem_addr(a_mem_addr), .mem_val(a_mem_val), .mem_get(a_mem_get), .mem_set(a_mem_set),
        .mem_out(a_mem_out), .grant_id(a_grant_id)
    );

    memory_arbiter #(.FAIR(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_write(1'b0), .req0_addr(b_req0_addr),
        .req0_wdata(8'h00), .req0_ready(b_req0_ready), .req0_rvalid(b_req0_rvalid),
        .req0_rdata(b_req0_rdata),
        .req1_valid(b_req1_valid), .req1_write(1'b0), .req1_addr(b_req1_addr),
        .req1_wdata(8'h00), .req1_ready(b_req1_ready), .req1_rvalid(b_req1_rvalid),
        .req1_rdata(b_req1_rdata),
        .mem_addr(b_mem_addr), .mem_val(b_mem_val), .mem_get(b_mem_get), .mem_set(b_mem_set),
        .mem_out(b_mem_out), .grant_id(b_grant_id)
    );

    // Memory models: synchronous write on set, registered read on get.
    always @(posedge clk) begin
        if (a_mem_set) mem_a[a_mem_addr] <= a_mem_val;
        if (a_mem_get) a_mem_out <= mem_a[a_mem_addr];
        if (b_mem_set) mem_b[b_mem_addr] <= b_mem_val;
        if (b_mem_get) b_mem_out <= mem_b[b_mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        compared++;
        if (a_outs !== 39'd0) begin failed++; $display("FAIL reset_a: got %h expected 0", a_outs); end
        compared++;
        if (b_outs !== 39'd0) begin failed++; $display("FAIL reset_b: got %h expected 0", b_outs); end
        #10 rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        a_req0_valid = 1; a_req0_write = 1; a_req0_addr = 8'h10; a_req0_wdata = 8'h5A;
        step();
        compared++;
        if ({a_req0_ready, a_mem_set, a_mem_get, a_mem_addr, a_mem_val} !== {1'b1, 1'b1, 1'b0, 8'h10, 8'h5A}) begin
            failed++; $display("FAIL wr_issue: got %b%b%b %h %h expected 110 10 5a",
                               a_req0_ready, a_mem_set, a_mem_get, a_mem_addr, a_mem_val);
        end
        a_req0_valid = 0;
        step();
        compared++;
        if ({a_req0_ready, a_mem_set, mem_a[8'h10]} !== {1'b0, 1'b0, 8'h5A}) begin
            failed++; $display("FAIL wr_commit: got %b%b %h expected 00 5a", a_req0_ready, a_mem_set, mem_a[8'h10]);
        end
        a_req0_valid = 1; a_req0_write = 0;
        step();
        compared++;
        if ({a_req0_ready, a_mem_get, a_mem_set} !== 3'b110) begin
            failed++; $display("FAIL rd_issue: got %b%b%b expected 110", a_req0_ready, a_mem_get, a_mem_set);
        end
        a_req0_valid = 0;
        step();
        compared++;
        if ({a_req0_ready, a_mem_get, a_req0_rvalid} !== 3'b000) begin
            failed++; $display("FAIL rd_resp: got %b%b%b expected 000", a_req0_ready, a_mem_get, a_req0_rvalid);
        end
        step();
        compared++;
        if ({a_req0_rvalid, a_req0_rdata} !== {1'b1, 8'h5A}) begin
            failed++; $display("FAIL rd_data: got %b %h expected 1 5a", a_req0_rvalid, a_req0_rdata);
        end
        compared++;
        if ({a_req1_ready, a_req1_rvalid, a_req1_rdata} !== 10'd0) begin
            failed++; $display("FAIL port1_quiet: got %b%b %h expected 00 00", a_req1_ready, a_req1_rvalid, a_req1_rdata);
        end
        step();
        compared++;
        if ({a_req0_rvalid, a_req0_rdata} !== {1'b0, 8'h5A}) begin
            failed++; $display("FAIL rd_hold: got %b %h expected 0 5a", a_req0_rvalid, a_req0_rdata);
        end
    endtask

    task automatic test_fair_contention();
        logic       exp;
        logic [7:0] exp_data;
        do_reset();
        a_req0_valid = 1; a_req0_write = 0; a_req0_addr = 8'h01;
        a_req1_valid = 1; a_req1_write = 0; a_req1_addr = 8'h02;
        for (int k = 0; k < 4; k++) begin
            exp      = k[0];
            exp_data = exp ? 8'h94 : 8'h97;
            step();
            compared++;
            if ({a_req1_ready, a_req0_ready, a_grant_id, a_mem_get} !== {exp, ~exp, exp, 1'b1}) begin
                failed++; $display("FAIL fair_grant%0d: got r1r0=%b%b id=%b get=%b expected id=%b",
                                   k, a_req1_ready, a_req0_ready, a_grant_id, a_mem_get, exp);
            end
            step();
            compared++;
            if (a_mem_get !== 1'b0) begin failed++; $display("FAIL fair_get_gap%0d: got %b expected 0", k, a_mem_get); end
            step();
            if (k == 3) begin a_req0_valid = 0; a_req1_valid = 0; end
            compared++;
            if ({a_req1_rvalid, a_req0_rvalid, (exp ? a_req1_rdata : a_req0_rdata)} !== {exp, ~exp, exp_data}) begin
                failed++; $display("FAIL fair_data%0d: got rv=%b%b data=%h expected data=%h",
                                   k, a_req1_rvalid, a_req0_rvalid, exp ? a_req1_rdata : a_req0_rdata, exp_data);
            end
        end
        step();
    endtask

    task automatic test_fixed_priority();
        b_req0_valid = 1; b_req0_addr = 8'h01;
        b_req1_valid = 1; b_req1_addr = 8'h02;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) b_req1_valid = 0;
            step();
            compared++;
            if ({b_req1_ready, b_req0_ready, b_grant_id, b_mem_get & b_mem_set} !== 4'b0100) begin
                failed++; $display("FAIL prio_grant%0d: got r1r0=%b%b id=%b both=%b expected 0100",
                                   k, b_req1_ready, b_req0_ready, b_grant_id, b_mem_get & b_mem_set);
            end
            step();
            compared++;
            if ((b_mem_get & b_mem_set) !== 1'b0) begin failed++; $display("FAIL prio_excl%0d: got 1 expected 0", k); end
            step();
            if (k == 4) b_req0_valid = 0;
            compared++;
            if ({b_req0_rvalid, b_req0_rdata, b_req1_rvalid} !== {1'b1, 8'h97, 1'b0}) begin
                failed++; $display("FAIL prio_data%0d: got %b %h %b expected 1 97 0", k, b_req0_rvalid, b_req0_rdata, b_req1_rvalid);
            end
        end
        step();
        compared++;
        if ({b_mem_get, b_req1_rdata} !== 9'd0) begin
            failed++; $display("FAIL prio_starved: got get=%b rdata1=%h expected 0 00", b_mem_get, b_req1_rdata);
        end
    endtask

    task automatic test_coherence();
        a_req1_valid = 1; a_req1_write = 1; a_req1_addr = 8'hFF; a_req1_wdata = 8'hC3;
        step();
        compared++;
        if ({a_req1_ready, a_mem_set} !== 2'b11) begin
            failed++; $display("FAIL coh_wr: got %b%b expected 11", a_req1_ready, a_mem_set);
        end
        a_req1_valid = 0;
        a_req0_valid = 1; a_req0_write = 0; a_req0_addr = 8'hFF;
        step();
        compared++;
        if ({a_req0_ready, a_mem_set, a_mem_get} !== 3'b000) begin
            failed++; $display("FAIL coh_wait: got %b%b%b expected 000", a_req0_ready, a_mem_set, a_mem_get);
        end
        step();
        compared++;
        if ({a_req0_ready, a_grant_id, a_mem_get, a_mem_addr} !== {3'b101, 8'hFF}) begin
            failed++; $display("FAIL coh_rd: got %b%b%b %h expected 101 ff", a_req0_ready, a_grant_id, a_mem_get, a_mem_addr);
        end
        a_req0_valid = 0;
        step();
        step();
        compared++;
        if ({a_req0_rvalid, a_req0_rdata} !== {1'b1, 8'hC3}) begin
            failed++; $display("FAIL coh_data: got %b %h expected 1 c3", a_req0_rvalid, a_req0_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_write();
        a_req0_valid = 1; a_req0_write = 1; a_req0_addr = 8'h20; a_req0_wdata = 8'h77;
        step();
        a_req0_valid = 0;
        compared++;
        if (a_mem_set !== 1'b1) begin failed++; $display("FAIL rst_wr_issue: got %b expected 1", a_mem_set); end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (a_outs !== 39'd0) begin failed++; $display("FAIL rst_mid_outs: got %h expected 0", a_outs); end
        @(negedge clk);
        @(negedge clk) rst_n = 1'b1;
        compared++;
        if (mem_a[8'h20] !== 8'hB6) begin failed++; $display("FAIL rst_no_write: got %h expected b6", mem_a[8'h20]); end
        a_req0_valid = 1; a_req0_write = 0; a_req0_addr = 8'h20;
        step();
        a_req0_valid = 0;
        step();
        step();
        compared++;
        if ({a_req0_rvalid, a_req0_rdata} !== {1'b1, 8'hB6}) begin
            failed++; $display("FAIL rst_old_data: got %b %h expected 1 b6", a_req0_rvalid, a_req0_rdata);
        end
    endtask

    task automatic test_abandoned();
        a_req0_valid = 1; a_req0_write = 0; a_req0_addr = 8'h01;
        step();
        a_req0_valid = 0;
        step();
        a_req1_valid = 1; a_req1_write = 1; a_req1_addr = 8'h55; a_req1_wdata = 8'h11;
        #3 a_req1_valid = 0;
        step();
        compared++;
        if ({a_req0_rvalid, a_req0_rdata, a_req1_ready} !== {1'b1, 8'h97, 1'b0}) begin
            failed++; $display("FAIL abandon_resp: got %b %h r1=%b expected 1 97 0", a_req0_rvalid, a_req0_rdata, a_req1_ready);
        end
        step();
        compared++;
        if ({a_req1_ready, a_mem_set, a_mem_get, mem_a[8'h55]} !== {3'b000, 8'hC3}) begin
            failed++; $display("FAIL abandon_idle: got %b%b%b %h expected 000 c3",
                               a_req1_ready, a_mem_set, a_mem_get, mem_a[8'h55]);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'(i) ^ 8'h96;
            mem_b[i] = 8'(i) ^ 8'h96;
        end
        test_reset();
        test_write_read();
        test_fair_contention();
        test_fixed_priority();
        test_coherence();
        test_reset_mid_write();
        test_abandoned();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
